// File: rtl/float_alu_pkg.sv
// Shared definitions for the float_alu arbiter slice.
//   - default requester count and WAIT watchdog length
//   - XZOUI flag bit positions within the 5-bit flag vector
//   - arbiter FSM state encoding (also exported on the debug port)
package float_alu_pkg;

  localparam int DEFAULT_NUM_REQ = 2;
  localparam int DEFAULT_TIMEOUT = 64;

  localparam int FLAG_I = 0;
  localparam int FLAG_U = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_X = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/float_alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this round
//   grant : one-hot winner (first set req bit at or after ptr, wrapping);
//           all zero when req is zero
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick_src;

  // Bits at or above ptr. If any of those request, the lowest of them wins;
  // otherwise the search wraps and the lowest request overall wins.
  assign upper_mask = ~((N'(1) << ptr) - N'(1));
  assign masked     = req & upper_mask;
  assign pick_src   = (masked != '0) ? masked : req;
  // Isolate the lowest set bit: x & -x.
  assign grant      = pick_src & (~pick_src + N'(1));

endmodule

// File: rtl/float_alu_arbiter.sv
// float_alu_arbiter: shares one float_alu among NUM_REQ requesters, one
// operation in flight at a time.
//
// Handshakes (all valid/ready pairs): a transfer happens in a cycle where
// both valid and ready are high at the rising edge; valid, once raised, is
// held with its payload stable until the transfer; ready may depend
// combinationally on valid.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake
//   req_op_a/op_b/op_code    packed per-requester payload (requester 0 in LSBs)
//   req_round_mode/mode_fp   per-requester rounding mode and precision
//   rsp_valid/rsp_ready      per-requester response handshake
//   rsp_result/flags/timeout shared response payload, held until next capture
//   alu_*                    float_alu issue side and result side
//   dbg_state                current FSM state (float_alu_pkg::arb_state_e)
module float_alu_arbiter
  import float_alu_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_op_a,
  input  logic [NUM_REQ*32-1:0] req_op_b,
  input  logic [NUM_REQ*3-1:0]  req_op_code,
  input  logic [NUM_REQ-1:0]    req_round_mode,
  input  logic [NUM_REQ-1:0]    req_mode_fp,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic [4:0]            rsp_flags,
  output logic                  rsp_timeout,
  output logic [31:0]           alu_op_a,
  output logic [31:0]           alu_op_b,
  output logic [2:0]            alu_op_code,
  output logic                  alu_round_mode,
  output logic                  alu_mode_fp,
  output logic                  alu_start,
  output logic                  alu_ready_in,
  input  logic                  alu_ready_out,
  input  logic                  alu_valid_out,
  input  logic [31:0]           alu_result,
  input  logic [4:0]            alu_flags,
  output logic [1:0]            dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      op_a_q, op_b_q;
  logic [2:0]       op_code_q;
  logic             round_q, fp_q;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win_idx;
  logic [31:0]        win_a, win_b;
  logic [2:0]         win_code;
  logic               win_rm, win_fp;
  logic               accept, rsp_hs, alu_done, wd_fire;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // One-hot grant selects the winner's payload.
  always_comb begin
    win_idx  = '0;
    win_a    = '0;
    win_b    = '0;
    win_code = '0;
    win_rm   = 1'b0;
    win_fp   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx  = PTR_W'(i);
        win_a    = req_op_a[i*32 +: 32];
        win_b    = req_op_b[i*32 +: 32];
        win_code = req_op_code[i*3 +: 3];
        win_rm   = req_round_mode[i];
        win_fp   = req_mode_fp[i];
      end
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign rsp_hs   = |(rsp_valid & rsp_ready);
  assign alu_done = (state_q == S_WAIT) && alu_valid_out;
  // A real result in the last watchdog cycle wins over the forced error.
  assign wd_fire  = (state_q == S_WAIT) && !alu_valid_out && (cnt_q == CNT_LAST);

  always_comb begin
    state_d        = state_q;
    req_ready      = '0;
    rsp_valid      = '0;
    alu_start      = 1'b0;
    alu_ready_in   = 1'b0;
    alu_op_a       = op_a_q;
    alu_op_b       = op_b_q;
    alu_op_code    = op_code_q;
    alu_round_mode = round_q;
    alu_mode_fp    = fp_q;
    dbg_state      = state_q;
    case (state_q)
      S_IDLE: begin
        // Grants are masked while reset is asserted so nothing is accepted
        // on a reset edge.
        if (alu_ready_out && !rst) req_ready = grant;
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        alu_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        alu_ready_in = 1'b1;
        if (alu_done || wd_fire) state_d = S_RESP;
      end
      S_RESP: begin
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = (owner_q == PTR_W'(i));
        if (rsp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= '0;
      round_q     <= 1'b0;
      fp_q        <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q   <= win_idx;
        op_a_q    <= win_a;
        op_b_q    <= win_b;
        op_code_q <= win_code;
        round_q   <= win_rm;
        fp_q      <= win_fp;
      end
      // Counter is zero on the first WAIT cycle.
      if (state_q == S_ISSUE) cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if (alu_done) begin
        rsp_result  <= alu_result;
        rsp_flags   <= alu_flags;
        rsp_timeout <= 1'b0;
      end else if (wd_fire) begin
        rsp_result  <= '0;
        rsp_flags   <= 5'(1) << FLAG_I;
        rsp_timeout <= 1'b1;
      end
      if ((state_q == S_RESP) && rsp_hs)
        rr_ptr_q <= (owner_q == LAST_REQ) ? '0 : owner_q + PTR_W'(1);
    end
  end

endmodule
